stats_text_engine: RTL and testbench

- Character-cell text source for the stats panel: an 8x8 grid of 8x8-pixel glyph cells.
- Keeps a 64-entry character buffer holding generation number and speed level as formatted decimal text.
- A sequential binary-to-BCD formatter rewrites the buffer on each stats update.
- Answers per-pixel glyph lookups from the stats overlay with a fixed 2-cycle latency, returning 24-bit RGB to the display mux.

---
 rtl/stats_text_engine.sv | 351 +++++++++++++++++++++++++++++++++++
 tb/tb_stats_text_engine.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stats_text_engine.sv
`default_nettype none
// ============================================================================
// Module      : stats_text_engine
// Description : Character-cell text source for the stats panel. An 8x8 grid
//               of 8x8-pixel glyph cells is backed by a 64-entry character
//               buffer. A sequential double-dabble formatter rewrites the
//               generation and speed fields after each stats update. Pixel
//               lookups are answered with a fixed 2-cycle latency.
//
// Ports       : clk              system clock
//               rst_b            asynchronous active-low reset
//               stat_update      pulse: capture gen_num/speed_lvl, reformat
//               gen_num[15:0]    generation number (unsigned)
//               speed_lvl[3:0]   speed level, values above 9 show as 9
//               alive_cnt[15:0]  live-cell count (STS_ALIVE_COUNT_EN only)
//               sts_get_char_val pixel lookup request valid
//               sts_char_num[5:0] cell index {row[2:0], col[2:0]}
//               sts_pixR[2:0]    pixel row inside cell
//               sts_pixC[2:0]    pixel column inside cell, 0 = leftmost
//               sts_pix_val[23:0] RGB for the request issued 2 cycles earlier
//               fmt_busy         formatter active
//
// Options     : define STS_ALIVE_COUNT_EN to add the "ALIVE" label and the
//               alive_cnt field on rows 6-7 (44-cycle reformat instead of 23).
//
// Revision    : 1.0  initial release
// ============================================================================
module stats_text_engine #(
    parameter logic [23:0] FG_RGB = 24'hFFFFFF,
    parameter logic [23:0] BG_RGB = 24'h000000
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        stat_update,
    input  logic [15:0] gen_num,
    input  logic [3:0]  speed_lvl,
`ifdef STS_ALIVE_COUNT_EN
    input  logic [15:0] alive_cnt,
`endif
    input  logic        sts_get_char_val,
    input  logic [5:0]  sts_char_num,
    input  logic [2:0]  sts_pixR,
    input  logic [2:0]  sts_pixC,
    output logic [23:0] sts_pix_val,
    output logic        fmt_busy
);

    localparam logic [5:0] c_blank     = 6'd36;
    localparam logic [5:0] c_gen_base  = 6'd11;   // row 1, col 3
    localparam logic [5:0] c_spd_cell  = 6'd39;   // row 4, col 7
`ifdef STS_ALIVE_COUNT_EN
    localparam logic [5:0] c_alv_base  = 6'd59;   // row 7, col 3
`endif

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LATCH   = 3'd1,
        ST_CONV    = 3'd2,
        ST_WRITE   = 3'd3,
        ST_CONV_A  = 3'd4,
        ST_WRITE_A = 3'd5
    } state_t;

    // Glyph bitmaps: byte 7 (bits 63:56) is the top row, MSB of each byte is
    // the leftmost pixel. Codes 36..63 render blank.
    function automatic logic [63:0] f_glyph(input logic [5:0] code);
        case (code)
            6'd0:    f_glyph = 64'h3C666E7666663C00;
            6'd1:    f_glyph = 64'h1838181818187E00;
            6'd2:    f_glyph = 64'h3C66060C30607E00;
            6'd3:    f_glyph = 64'h3C66061C06663C00;
            6'd4:    f_glyph = 64'h0C1C3C6C7E0C0C00;
            6'd5:    f_glyph = 64'h7E607C0606663C00;
            6'd6:    f_glyph = 64'h3C66607C66663C00;
            6'd7:    f_glyph = 64'h7E660C1818181800;
            6'd8:    f_glyph = 64'h3C66663C66663C00;
            6'd9:    f_glyph = 64'h3C66663E06663C00;
            6'd10:   f_glyph = 64'h183C667E66666600;
            6'd11:   f_glyph = 64'h7C66667C66667C00;
            6'd12:   f_glyph = 64'h3C66606060663C00;
            6'd13:   f_glyph = 64'h786C6666666C7800;
            6'd14:   f_glyph = 64'h7E60607860607E00;
            6'd15:   f_glyph = 64'h7E60607860606000;
            6'd16:   f_glyph = 64'h3C66606E66663C00;
            6'd17:   f_glyph = 64'h6666667E66666600;
            6'd18:   f_glyph = 64'h3C18181818183C00;
            6'd19:   f_glyph = 64'h1E0C0C0C0C6C3800;
            6'd20:   f_glyph = 64'h666C7870786C6600;
            6'd21:   f_glyph = 64'h6060606060607E00;
            6'd22:   f_glyph = 64'h63777F6B63636300;
            6'd23:   f_glyph = 64'h66767E7E6E666600;
            6'd24:   f_glyph = 64'h3C66666666663C00;
            6'd25:   f_glyph = 64'h7C66667C60606000;
            6'd26:   f_glyph = 64'h3C666666663C0E00;
            6'd27:   f_glyph = 64'h7C66667C786C6600;
            6'd28:   f_glyph = 64'h3C66603C06663C00;
            6'd29:   f_glyph = 64'h7E18181818181800;
            6'd30:   f_glyph = 64'h6666666666663C00;
            6'd31:   f_glyph = 64'h66666666663C1800;
            6'd32:   f_glyph = 64'h6363636B7F776300;
            6'd33:   f_glyph = 64'h66663C183C666600;
            6'd34:   f_glyph = 64'h6666663C18181800;
            6'd35:   f_glyph = 64'h7E060C1830607E00;
            default: f_glyph = 64'h0000000000000000;
        endcase
    endfunction

    // Power-up layout: labels plus a single "0" in each numeric field.
    function automatic logic [5:0] f_layout(input int idx);
        case (idx)
            0:       f_layout = 6'd16;   // G
            1:       f_layout = 6'd14;   // E
            2:       f_layout = 6'd23;   // N
            15:      f_layout = 6'd0;
            24:      f_layout = 6'd28;   // S
            25:      f_layout = 6'd25;   // P
            26:      f_layout = 6'd14;   // E
            27:      f_layout = 6'd14;   // E
            28:      f_layout = 6'd13;   // D
            39:      f_layout = 6'd0;
`ifdef STS_ALIVE_COUNT_EN
            48:      f_layout = 6'd10;   // A
            49:      f_layout = 6'd21;   // L
            50:      f_layout = 6'd18;   // I
            51:      f_layout = 6'd31;   // V
            52:      f_layout = 6'd14;   // E
            63:      f_layout = 6'd0;
`endif
            default: f_layout = c_blank;
        endcase
    endfunction

    // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
    function automatic logic [19:0] f_adj(input logic [19:0] bcd);
        for (int i = 0; i < 5; i++) begin
            f_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3
                                                      : bcd[4*i +: 4];
        end
    endfunction

    // ------------------------------------------------------------------
    // Character buffer
    // ------------------------------------------------------------------
    logic [5:0]  r_buf [64];
    logic        w_wr_en;
    logic [5:0]  w_wr_addr;
    logic [5:0]  w_wr_data;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < 64; i++) begin
                r_buf[i] <= f_layout(i);
            end
        end else if (w_wr_en) begin
            r_buf[w_wr_addr] <= w_wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Lookup pipeline
    // ------------------------------------------------------------------
    logic        r_req_v;
    logic [5:0]  r_req_num;
    logic [2:0]  r_req_row;
    logic [2:0]  r_req_col;
    logic        r_v1;
    logic [7:0]  r_font_row;
    logic [2:0]  r_col1;
    logic [63:0] w_glyph;
    logic [7:0]  w_font_row;

    // A write landing on the cell being read shows up one cycle later, since
    // the buffer read sees the register contents before the edge.
    assign w_glyph    = f_glyph(r_buf[r_req_num]);
    assign w_font_row = w_glyph[{~r_req_row, 3'b000} +: 8];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_req_v    <= 1'b0;
            r_req_num  <= 6'd0;
            r_req_row  <= 3'd0;
            r_req_col  <= 3'd0;
            r_v1       <= 1'b0;
            r_font_row <= 8'd0;
            r_col1     <= 3'd0;
        end else begin
            r_req_v    <= sts_get_char_val;
            r_req_num  <= sts_char_num;
            r_req_row  <= sts_pixR;
            r_req_col  <= sts_pixC;
            r_v1       <= r_req_v;
            r_font_row <= w_font_row;
            r_col1     <= r_req_col;
        end
    end

    // Column 0 is the MSB of the font row byte.
    assign sts_pix_val = (r_v1 && r_font_row[~r_col1]) ? FG_RGB : BG_RGB;

    // ------------------------------------------------------------------
    // Formatter FSM
    // ------------------------------------------------------------------
    state_t      r_state;
    logic        r_busy;
    logic        r_pending;
    logic [15:0] r_bin;
    logic [19:0] r_bcd;
    logic [3:0]  r_spd;
    logic [3:0]  r_cnt;
    logic [2:0]  r_widx;
    logic        r_seen;
`ifdef STS_ALIVE_COUNT_EN
    logic [15:0] r_alive;
`endif
    logic [19:0] w_adj;
    logic [35:0] w_shift;
    logic [3:0]  w_digit;
    logic [5:0]  w_digit_code;

    assign w_adj    = f_adj(r_bcd);
    assign w_shift  = {w_adj, r_bin} << 1;
    assign fmt_busy = r_busy;

    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = 6'd0;
        w_wr_data = c_blank;
        case (r_widx)
            3'd0:    w_digit = r_bcd[19:16];
            3'd1:    w_digit = r_bcd[15:12];
            3'd2:    w_digit = r_bcd[11:8];
            3'd3:    w_digit = r_bcd[7:4];
            default: w_digit = r_bcd[3:0];
        endcase
        // Leading zeros blank out; the units column always shows a digit.
        w_digit_code = (w_digit == 4'd0 && !r_seen && r_widx != 3'd4)
                       ? c_blank : {2'b00, w_digit};
        if (r_state == ST_WRITE) begin
            w_wr_en = 1'b1;
            if (r_widx == 3'd5) begin
                w_wr_addr = c_spd_cell;
                w_wr_data = {2'b00, r_spd};
            end else begin
                w_wr_addr = c_gen_base + {3'b000, r_widx};
                w_wr_data = w_digit_code;
            end
        end
`ifdef STS_ALIVE_COUNT_EN
        if (r_state == ST_WRITE_A) begin
            w_wr_en   = 1'b1;
            w_wr_addr = c_alv_base + {3'b000, r_widx};
            w_wr_data = w_digit_code;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_pending <= 1'b0;
            r_bin     <= 16'd0;
            r_bcd     <= 20'd0;
            r_spd     <= 4'd0;
            r_cnt     <= 4'd0;
            r_widx    <= 3'd0;
            r_seen    <= 1'b0;
`ifdef STS_ALIVE_COUNT_EN
            r_alive   <= 16'd0;
`endif
        end else begin
            if (r_state != ST_IDLE && stat_update) begin
                r_pending <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (stat_update) begin
                        r_state <= ST_LATCH;
                        r_busy  <= 1'b1;
                    end
                end
                ST_LATCH: begin
                    r_bin   <= gen_num;
                    r_spd   <= (speed_lvl > 4'd9) ? 4'd9 : speed_lvl;
`ifdef STS_ALIVE_COUNT_EN
                    r_alive <= alive_cnt;
`endif
                    r_bcd   <= 20'd0;
                    r_cnt   <= 4'd0;
                    r_state <= ST_CONV;
                end
                ST_CONV, ST_CONV_A: begin
                    r_bcd <= w_shift[35:16];
                    r_bin <= w_shift[15:0];
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd15) begin
                        r_state <= (r_state == ST_CONV) ? ST_WRITE : ST_WRITE_A;
                        r_widx  <= 3'd0;
                        r_seen  <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    r_widx <= r_widx + 3'd1;
                    if (w_digit != 4'd0) begin
                        r_seen <= 1'b1;
                    end
                    if (r_widx == 3'd5) begin
`ifdef STS_ALIVE_COUNT_EN
                        r_state <= ST_CONV_A;
                        r_bin   <= r_alive;
                        r_bcd   <= 20'd0;
                        r_cnt   <= 4'd0;
`else
                        // Pulses seen while busy collapse into one rerun.
                        r_pending <= 1'b0;
                        if (r_pending || stat_update) begin
                            r_state <= ST_LATCH;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
`endif
                    end
                end
`ifdef STS_ALIVE_COUNT_EN
                ST_WRITE_A: begin
                    r_widx <= r_widx + 3'd1;
                    if (w_digit != 4'd0) begin
                        r_seen <= 1'b1;
                    end
                    if (r_widx == 3'd4) begin
                        r_pending <= 1'b0;
                        if (r_pending || stat_update) begin
                            r_state <= ST_LATCH;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stats_text_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_stats_text_engine
// Description : Directed self-checking bench for stats_text_engine (default
//               build). Cells are read back through the pixel lookup port and
//               compared against a locally kept expected character layout.
// Revision    : 1.0  initial release
// ============================================================================
module tb_stats_text_engine;

    localparam logic [23:0] FG = 24'hFFFFFF;
    localparam logic [23:0] BG = 24'h000000;

    logic        clk;
    logic        rst_b;
    logic        stat_update;
    logic [15:0] gen_num;
    logic [3:0]  speed_lvl;
    logic        sts_get_char_val;
    logic [5:0]  sts_char_num;
    logic [2:0]  sts_pixR;
    logic [2:0]  sts_pixC;
    logic [23:0] sts_pix_val;
    logic        fmt_busy;

    int checks = 0;
    int errors = 0;

    logic [5:0] exp_code [64];
    logic [5:0] old_code [64];

    stats_text_engine #(.FG_RGB(FG), .BG_RGB(BG)) dut (
        .clk              (clk),
        .rst_b            (rst_b),
        .stat_update      (stat_update),
        .gen_num          (gen_num),
        .speed_lvl        (speed_lvl),
        .sts_get_char_val (sts_get_char_val),
        .sts_char_num     (sts_char_num),
        .sts_pixR         (sts_pixR),
        .sts_pixC         (sts_pixC),
        .sts_pix_val      (sts_pix_val),
        .fmt_busy         (fmt_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Hand-entered glyphs for the codes that appear in the checked cells.
    function automatic logic [63:0] glyph(input logic [5:0] c);
        case (c)
            6'd0:    glyph = 64'h3C666E7666663C00;
            6'd1:    glyph = 64'h1838181818187E00;
            6'd2:    glyph = 64'h3C66060C30607E00;
            6'd3:    glyph = 64'h3C66061C06663C00;
            6'd4:    glyph = 64'h0C1C3C6C7E0C0C00;
            6'd5:    glyph = 64'h7E607C0606663C00;
            6'd6:    glyph = 64'h3C66607C66663C00;
            6'd7:    glyph = 64'h7E660C1818181800;
            6'd8:    glyph = 64'h3C66663C66663C00;
            6'd9:    glyph = 64'h3C66663E06663C00;
            6'd13:   glyph = 64'h786C6666666C7800;
            6'd14:   glyph = 64'h7E60607860607E00;
            6'd16:   glyph = 64'h3C66606E66663C00;
            6'd23:   glyph = 64'h66767E7E6E666600;
            6'd25:   glyph = 64'h7C66667C60606000;
            6'd28:   glyph = 64'h3C66603C06663C00;
            default: glyph = 64'h0;
        endcase
    endfunction

    function automatic void set_reset_layout();
        for (int i = 0; i < 64; i++) exp_code[i] = 6'd36;
        exp_code[0]  = 6'd16; exp_code[1]  = 6'd14; exp_code[2]  = 6'd23;
        exp_code[24] = 6'd28; exp_code[25] = 6'd25; exp_code[26] = 6'd14;
        exp_code[27] = 6'd14; exp_code[28] = 6'd13;
        exp_code[15] = 6'd0;  exp_code[39] = 6'd0;
    endfunction

    // Decimal formatting with division, independent of the DUT's shifter.
    function automatic void model_update(input int g, input int s);
        int  div [5] = '{10000, 1000, 100, 10, 1};
        int  d;
        bit  seen;
        for (int i = 0; i < 64; i++) old_code[i] = exp_code[i];
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            d = (g / div[i]) % 10;
            if (d == 0 && !seen && i < 4) exp_code[11 + i] = 6'd36;
            else begin
                exp_code[11 + i] = 6'(d);
                seen = 1;
            end
        end
        exp_code[39] = (s > 9) ? 6'd9 : 6'(s);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reads all 64 pixels of a cell back-to-back through the lookup port.
    task automatic read_cell(input int idx, output logic [63:0] bm, output bit bad);
        bm  = 64'h0;
        bad = 0;
        for (int k = 0; k <= 64; k++) begin
            if (k < 64) begin
                sts_get_char_val = 1'b1;
                sts_char_num     = 6'(idx);
                sts_pixR         = 3'(k / 8);
                sts_pixC         = 3'(k % 8);
            end else begin
                sts_get_char_val = 1'b0;
            end
            tick();
            if (k >= 1) begin
                if (sts_pix_val === FG) bm[63 - (k - 1)] = 1'b1;
                else if (sts_pix_val !== BG) bad = 1;
            end
        end
    endtask

    task automatic check_cell(input int idx);
        logic [63:0] bm;
        logic [63:0] eg;
        bit          bad;
        read_cell(idx, bm, bad);
        eg = glyph(exp_code[idx]);
        checks++;
        assert (bm === eg && !bad) else begin
            errors++;
            $error("FAIL cell%0d observed %h (bad colour %0d) expected %h", idx, bm, bad, eg);
        end
    endtask

    task automatic check_layout();
        int cells [12] = '{0, 1, 2, 11, 12, 13, 14, 15, 24, 28, 39, 63};
        for (int i = 0; i < 12; i++) check_cell(cells[i]);
    endtask

    task automatic pulse_update(input int g, input int s);
        gen_num     = 16'(g);
        speed_lvl   = 4'(s);
        stat_update = 1'b1;
        tick();
        stat_update = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (fmt_busy === 1'b1 && n < 500) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int          n;
        int          j;
        int          bi;
        int          rq_cell [81];
        int          rq_r    [81];
        int          rq_c    [81];
        logic [63:0] g_old;
        logic [63:0] g_new;
        logic [23:0] e_old;
        logic [23:0] e_new;
        bit          quiet;

        rst_b = 1'b0; stat_update = 1'b0; gen_num = 16'd0; speed_lvl = 4'd0;
        sts_get_char_val = 1'b0; sts_char_num = 6'd0; sts_pixR = 3'd0; sts_pixC = 3'd0;
        #12;
        checks++;
        assert (sts_pix_val === BG) else begin
            errors++; $error("FAIL rst_pix observed %h expected %h", sts_pix_val, BG);
        end
        checks++;
        assert (fmt_busy === 1'b0) else begin
            errors++; $error("FAIL rst_busy observed %b expected 0", fmt_busy);
        end
        rst_b = 1'b1;
        tick();

        // Two-cycle latency on a set pixel of '0' (row 1, col 1).
        sts_get_char_val = 1'b1; sts_char_num = 6'o17; sts_pixR = 3'd1; sts_pixC = 3'd1;
        tick();
        sts_get_char_val = 1'b0;
        checks++;
        assert (sts_pix_val === BG) else begin
            errors++; $error("FAIL lat1 observed %h expected %h", sts_pix_val, BG);
        end
        tick();
        checks++;
        assert (sts_pix_val === FG) else begin
            errors++; $error("FAIL lat2 observed %h expected %h", sts_pix_val, FG);
        end
        tick();
        checks++;
        assert (sts_pix_val === BG) else begin
            errors++; $error("FAIL idle_slot observed %h expected %h", sts_pix_val, BG);
        end

        set_reset_layout();
        check_cell(8'o17);
        check_cell(8'o10);
        check_layout();

        // 1234 / speed 5: busy for exactly 23 cycles.
        pulse_update(1234, 5);
        wait_idle(n);
        checks++;
        assert (n === 23) else begin
            errors++; $error("FAIL busy_len observed %0d expected 23", n);
        end
        model_update(1234, 5);
        check_layout();

        pulse_update(65535, 3);
        wait_idle(n);
        model_update(65535, 3);
        check_layout();

        pulse_update(0, 12);
        wait_idle(n);
        model_update(0, 12);
        check_layout();

        // Two extra pulses during conversion collapse into one rerun.
        pulse_update(1234, 5);
        n = 0;
        while (fmt_busy === 1'b1 && n < 500) begin
            if (n == 5) begin
                gen_num = 16'd42; stat_update = 1'b1;
            end else if (n == 8) begin
                gen_num = 16'd43; stat_update = 1'b1;
            end else begin
                stat_update = 1'b0;
            end
            n++;
            tick();
        end
        stat_update = 1'b0;
        checks++;
        assert (n === 46) else begin
            errors++; $error("FAIL rerun_len observed %0d expected 46", n);
        end
        model_update(43, 5);
        check_layout();

        // Continuous lookup sweep across a full reformat.
        pulse_update(9876, 3);
        model_update(9876, 3);
        for (int k = 0; k <= 80; k++) begin
            if (k < 80) begin
                rq_cell[k] = k % 64; rq_r[k] = k % 8; rq_c[k] = (k / 8) % 8;
                sts_get_char_val = 1'b1;
                sts_char_num     = 6'(rq_cell[k]);
                sts_pixR         = 3'(rq_r[k]);
                sts_pixC         = 3'(rq_c[k]);
            end else begin
                sts_get_char_val = 1'b0;
            end
            tick();
            if (k >= 1) begin
                j     = k - 1;
                bi    = 63 - (rq_r[j] * 8 + rq_c[j]);
                g_old = glyph(old_code[rq_cell[j]]);
                g_new = glyph(exp_code[rq_cell[j]]);
                e_old = g_old[bi] ? FG : BG;
                e_new = g_new[bi] ? FG : BG;
                checks++;
                assert (sts_pix_val === e_old || sts_pix_val === e_new) else begin
                    errors++;
                    $error("FAIL sweep%0d observed %h expected %h or %h", j, sts_pix_val, e_old, e_new);
                end
            end
        end
        checks++;
        assert (fmt_busy === 1'b0) else begin
            errors++; $error("FAIL sweep_busy observed %b expected 0", fmt_busy);
        end
        check_layout();

        // Reset during conversion with a rerun pending.
        pulse_update(555, 1);
        sts_get_char_val = 1'b1; sts_char_num = 6'o17; sts_pixR = 3'd0; sts_pixC = 3'd2;
        tick(); tick(); tick();
        stat_update = 1'b1;
        tick();
        stat_update = 1'b0;
        tick();
        checks++;
        assert (sts_pix_val === FG && fmt_busy === 1'b1) else begin
            errors++; $error("FAIL pre_rst observed %h/%b expected %h/1", sts_pix_val, fmt_busy, FG);
        end
        #2;
        rst_b = 1'b0;
        #1;
        checks++;
        assert (sts_pix_val === BG) else begin
            errors++; $error("FAIL mid_rst_pix observed %h expected %h", sts_pix_val, BG);
        end
        checks++;
        assert (fmt_busy === 1'b0) else begin
            errors++; $error("FAIL mid_rst_busy observed %b expected 0", fmt_busy);
        end
        sts_get_char_val = 1'b0;
        tick();
        #2;
        rst_b = 1'b1;
        quiet = 1;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (fmt_busy !== 1'b0) quiet = 0;
        end
        checks++;
        assert (quiet) else begin
            errors++; $error("FAIL pending_cleared observed busy expected idle");
        end
        set_reset_layout();
        check_layout();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
